// File: rtl/laser_pkg.sv
// Shared constants and FSM state type for the LASER host driver.
// The optional watchdog is enabled with LASER_WDOG_EN (see laser_host_driver).
package laser_pkg;

  localparam int NPTS_C   = 40;
  localparam int CW_C     = 4;
  localparam int AW_C     = 6;
  localparam int RSTD_CYC = 2;

  typedef enum logic [2:0] {
    IDLE,
    RSTD,
    STRM,
    WAIT,
    RSLT
  } host_state_t;

endpackage

// File: rtl/laser_point_buf.sv
// Point buffer: NPTS entries of {x, y}, one synchronous write port,
// one combinational read port, synchronous clear on rst.
module laser_point_buf #(
  parameter int NPTS = 40,
  parameter int CW   = 4,
  parameter int AW   = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [2*CW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [2*CW-1:0] rdata
);

  localparam logic [AW-1:0] DEPTH = AW'(NPTS);

  logic [2*CW-1:0] mem [NPTS];

  // Out-of-range writes are dropped; out-of-range reads return 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPTS; i++) mem[i] <= '0;
    end else if (we && (waddr < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (raddr < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/laser_host_driver.sv
// Host driver for the LASER engine: buffers one image, streams it, returns centres.
// Define LASER_WDOG_EN to build the WAIT-state watchdog (parameter WDOG_CYC).
module laser_host_driver
  import laser_pkg::*;
#(
  parameter int NPTS     = NPTS_C,
  parameter int CW       = CW_C,
  parameter int WDOG_CYC = 40000
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            wr_en,
  input  logic [AW_C-1:0] wr_addr,
  input  logic [CW-1:0]   wr_x,
  input  logic [CW-1:0]   wr_y,
  input  logic            start,
  output logic            busy,
  output logic            laser_rst,
  output logic [CW-1:0]   X,
  output logic [CW-1:0]   Y,
  input  logic [CW-1:0]   l_c1x,
  input  logic [CW-1:0]   l_c1y,
  input  logic [CW-1:0]   l_c2x,
  input  logic [CW-1:0]   l_c2y,
  input  logic            l_done,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [CW-1:0]   res_c1x,
  output logic [CW-1:0]   res_c1y,
  output logic [CW-1:0]   res_c2x,
  output logic [CW-1:0]   res_c2y,
  output logic            res_timeout,
  output host_state_t     dbg_state
);

  localparam logic [AW_C-1:0] IDX_END   = AW_C'(NPTS);
  localparam logic [1:0]      RSTD_LAST = 2'(RSTD_CYC - 1);

  host_state_t       state;
  logic [AW_C-1:0]   idx;
  logic [1:0]        rcnt;
  logic              buf_we;
  logic [2*CW-1:0]   rd;

  assign dbg_state = state;
  assign buf_we    = wr_en && (state == IDLE);

  laser_point_buf #(.NPTS(NPTS), .CW(CW), .AW(AW_C)) u_buf (
    .clk   (CLK),
    .rst   (RST),
    .we    (buf_we),
    .waddr (wr_addr),
    .wdata ({wr_x, wr_y}),
    .raddr (idx),
    .rdata (rd)
  );

`ifdef LASER_WDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYC - 1);
  logic [15:0] wcnt;
`else
  assign res_timeout = 1'b0;
`endif

  // Result port: a result transfers on any edge where res_valid & res_ready;
  // while res_valid is high and res_ready is low, every res_* output holds.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      busy      <= 1'b0;
      laser_rst <= 1'b1;
      X         <= '0;
      Y         <= '0;
      idx       <= '0;
      rcnt      <= '0;
      res_valid <= 1'b0;
      res_c1x   <= '0;
      res_c1y   <= '0;
      res_c2x   <= '0;
      res_c2y   <= '0;
`ifdef LASER_WDOG_EN
      res_timeout <= 1'b0;
      wcnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          laser_rst <= 1'b1;
          if (start) begin
            state <= RSTD;
            busy  <= 1'b1;
            rcnt  <= '0;
            idx   <= '0;
          end
        end
        RSTD: begin
          if (rcnt == RSTD_LAST) begin
            laser_rst <= 1'b0;
            X         <= rd[2*CW-1:CW];
            Y         <= rd[CW-1:0];
            idx       <= idx + 1'b1;
            state     <= STRM;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        STRM: begin
          // idx==NPTS means the last point has been on X/Y for one cycle.
          if (idx == IDX_END) begin
            X     <= '0;
            Y     <= '0;
            state <= WAIT;
`ifdef LASER_WDOG_EN
            wcnt  <= '0;
`endif
          end else begin
            X   <= rd[2*CW-1:CW];
            Y   <= rd[CW-1:0];
            idx <= idx + 1'b1;
          end
        end
        WAIT: begin
          if (l_done) begin
            res_c1x   <= l_c1x;
            res_c1y   <= l_c1y;
            res_c2x   <= l_c2x;
            res_c2y   <= l_c2y;
            res_valid <= 1'b1;
            state     <= RSLT;
`ifdef LASER_WDOG_EN
            res_timeout <= 1'b0;
          end else if (wcnt == WDOG_LAST) begin
            res_c1x     <= '0;
            res_c1y     <= '0;
            res_c2x     <= '0;
            res_c2y     <= '0;
            res_valid   <= 1'b1;
            res_timeout <= 1'b1;
            state       <= RSLT;
          end else begin
            wcnt <= wcnt + 1'b1;
`endif
          end
        end
        RSLT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            laser_rst <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_host_driver.sv
// Bench for laser_host_driver: timeline reference model plus per-cycle compare.
// Define LASER_WDOG_EN to exercise the watchdog with WDOG_CYC=100.
module tb_laser_host_driver;
  import laser_pkg::*;

  localparam int NPTS = 40;
  localparam int CW   = 4;
  localparam int WDOG = 100;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          wr_en = 1'b0;
  logic [5:0]    wr_addr = '0;
  logic [CW-1:0] wr_x = '0, wr_y = '0;
  logic          start = 1'b0;
  logic          busy, laser_rst;
  logic [CW-1:0] X, Y;
  logic [CW-1:0] l_c1x = '0, l_c1y = '0, l_c2x = '0, l_c2y = '0;
  logic          l_done = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [CW-1:0] res_c1x, res_c1y, res_c2x, res_c2y;
  logic          res_timeout;
  host_state_t   dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  laser_host_driver #(.WDOG_CYC(WDOG)) dut (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
    .start(start), .busy(busy), .laser_rst(laser_rst), .X(X), .Y(Y),
    .l_c1x(l_c1x), .l_c1y(l_c1y), .l_c2x(l_c2x), .l_c2y(l_c2y), .l_done(l_done),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_c1x(res_c1x), .res_c1y(res_c1y), .res_c2x(res_c2x), .res_c2y(res_c2y),
    .res_timeout(res_timeout), .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A run is a timeline: d = edges since the accepted start. Points appear at
  // d = 2..NPTS+1, the engine may report done from d = NPTS+2 on.
  logic [CW-1:0] m_bx [NPTS];
  logic [CW-1:0] m_by [NPTS];
  bit            m_run = 1'b0;
  bit            m_rv  = 1'b0;
  bit            m_to  = 1'b0;
  int            m_d   = 0;
  logic [CW-1:0] m_r [4];

  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NPTS; i++) begin m_bx[i] = '0; m_by[i] = '0; end
      m_run = 1'b0; m_rv = 1'b0; m_to = 1'b0; m_d = 0;
      for (int i = 0; i < 4; i++) m_r[i] = '0;
    end else if (!m_run) begin
      if (wr_en && (int'(wr_addr) < NPTS)) begin
        m_bx[wr_addr] = wr_x;
        m_by[wr_addr] = wr_y;
      end
      if (start) begin m_run = 1'b1; m_d = 0; end
    end else if (m_rv) begin
      if (res_ready) begin m_rv = 1'b0; m_run = 1'b0; end
    end else if (m_d >= NPTS + 2 && l_done) begin
      m_rv = 1'b1; m_to = 1'b0;
      m_r[0] = l_c1x; m_r[1] = l_c1y; m_r[2] = l_c2x; m_r[3] = l_c2y;
`ifdef LASER_WDOG_EN
    end else if (m_d + 1 == NPTS + 2 + WDOG) begin
      m_rv = 1'b1; m_to = 1'b1;
      for (int i = 0; i < 4; i++) m_r[i] = '0;
`endif
    end else begin
      m_d++;
    end
  end

  // ---------------- scoreboard compare ----------------
  logic [CW-1:0] exp_q[$];
  bit            in_stream;

  always @(negedge CLK) begin
    if (chk_on) begin
      in_stream = m_run && !m_rv && m_d >= 2 && m_d < NPTS + 2;
      exp_q.delete();
      exp_q.push_back(in_stream ? m_bx[in_stream ? m_d - 2 : 0] : '0);
      exp_q.push_back(in_stream ? m_by[in_stream ? m_d - 2 : 0] : '0);
      check("busy", busy, m_run);
      check("laser_rst", laser_rst, (!m_run || m_d < 2));
      check("x", X, exp_q.pop_front());
      check("y", Y, exp_q.pop_front());
      check("res_valid", res_valid, m_rv);
      if (m_rv) begin
        check("res_c1x", res_c1x, m_r[0]);
        check("res_c1y", res_c1y, m_r[1]);
        check("res_c2x", res_c2x, m_r[2]);
        check("res_c2y", res_c2y, m_r[3]);
        check("res_timeout", res_timeout, m_to);
      end
`ifndef LASER_WDOG_EN
      check("res_timeout_tied", res_timeout, 0);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic write_pt(input int a, input int x, input int y);
    wr_en = 1'b1; wr_addr = 6'(a); wr_x = CW'(x); wr_y = CW'(y);
    step();
    wr_en = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // n edges of stream time with optional ignored traffic (writes, start, early done).
  task automatic stream_steps(input int n, input bit noise);
    for (int e = 0; e < n; e++) begin
      if (noise) begin
        wr_en   = 1'($urandom_range(0, 1));
        wr_addr = 6'($urandom_range(0, 63));
        wr_x    = CW'($urandom_range(0, 15));
        wr_y    = CW'($urandom_range(0, 15));
        start   = 1'($urandom_range(0, 1));
        l_done  = ($urandom_range(0, 3) == 0);
        l_c1x   = CW'($urandom_range(0, 15));
        res_ready = 1'($urandom_range(0, 1));
      end
      step();
      wr_en = 1'b0; start = 1'b0; l_done = 1'b0; res_ready = 1'b0;
    end
  endtask

  task automatic pulse_done(input int dly, input int c1x, input int c1y, input int c2x, input int c2y);
    steps(dly);
    l_c1x = CW'(c1x); l_c1y = CW'(c1y); l_c2x = CW'(c2x); l_c2y = CW'(c2y);
    l_done = 1'b1;
    step();
    l_done = 1'b0;
    l_c1x = CW'($urandom_range(0, 15)); l_c2y = CW'($urandom_range(0, 15));
  endtask

  task automatic handshake(input int rdy_dly);
    int t;
    t = 0;
    while (!res_valid && t < 20) begin step(); t++; end
    check("res_valid_seen", res_valid, 1);
    for (int i = 0; i < rdy_dly; i++) begin
      l_done = 1'($urandom_range(0, 1));
      l_c1y  = CW'($urandom_range(0, 15));
      step();
    end
    l_done = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic random_run();
    int nw;
    nw = $urandom_range(0, 8);
    for (int i = 0; i < nw; i++)
      write_pt($urandom_range(0, 47), $urandom_range(0, 15), $urandom_range(0, 15));
    start_run();
    stream_steps(NPTS + 2, 1'b1);
    pulse_done($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 15));
    handshake($urandom_range(0, 6));
    steps($urandom_range(0, 3));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    steps(3);
    chk_on = 1'b1;
    step();
    check("rst_laser_rst", laser_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_x", X, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_c1x", res_c1x, 0);
    check("rst_res_c2y", res_c2y, 0);
    check("rst_res_timeout", res_timeout, 0);
    RST = 1'b0;
    step();

    // Image k = (k%16, k/16*3), then stream timing.
    for (int k = 0; k < NPTS; k++) write_pt(k, k % 16, (k / 16) * 3);
    start_run();
    check("t1_rstd_a", laser_rst, 1);
    check("t1_busy", busy, 1);
    step();
    check("t1_rstd_b", laser_rst, 1);
    step();
    check("t1_beat0_rst", laser_rst, 0);
    check("t1_beat0_x", X, 0);
    steps(17);
    check("t1_beat17_x", X, 1);
    check("t1_beat17_y", Y, 3);
    steps(22);
    check("t1_beat39_x", X, 7);
    check("t1_beat39_y", Y, 6);
    step();
    check("t1_after_x", X, 0);
    check("t1_after_rst", laser_rst, 0);

    // Result (3,4),(9,10) with ready held low for 5 cycles.
    pulse_done(2, 3, 4, 9, 10);
    check("t2_valid", res_valid, 1);
    check("t2_c1x", res_c1x, 3);
    check("t2_c1y", res_c1y, 4);
    check("t2_c2x", res_c2x, 9);
    check("t2_c2y", res_c2y, 10);
    steps(5);
    check("t2_hold_c2y", res_c2y, 10);
    check("t2_hold_valid", res_valid, 1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("t2_busy_drop", busy, 0);
    check("t2_valid_drop", res_valid, 0);
    check("t2_laser_rst", laser_rst, 1);

    // start + write to addr 5 during STRM are ignored.
    start_run();
    steps(10);
    start = 1'b1; wr_en = 1'b1; wr_addr = 6'd5; wr_x = 4'd15; wr_y = 4'd15;
    step();
    start = 1'b0; wr_en = 1'b0;
    stream_steps(NPTS + 2 - 11, 1'b0);
    pulse_done(0, 1, 2, 3, 4);
    handshake(0);
    start_run();
    steps(7);
    check("t3_old_buf5_x", X, 5);
    check("t3_old_buf5_y", Y, 0);
    stream_steps(NPTS + 2 - 7, 1'b0);
    pulse_done(1, 5, 6, 7, 8);
    handshake(1);

    // Out-of-range write dropped; write+start in one cycle uses the new point.
    write_pt(40, 9, 9);
    wr_en = 1'b1; wr_addr = 6'd0; wr_x = 4'd7; wr_y = 4'd7; start = 1'b1;
    step();
    wr_en = 1'b0; start = 1'b0;
    steps(2);
    check("t4_first_x", X, 7);
    check("t4_first_y", Y, 7);
    steps(39);
    check("t4_last_x", X, 7);
    check("t4_last_y", Y, 6);
    step();
    pulse_done(0, 15, 0, 15, 0);
    handshake(2);

    for (int r = 0; r < 8; r++) random_run();

    // RST at stream beat 20 abandons the run and clears the buffer.
    start_run();
    steps(22);
    RST = 1'b1;
    step();
    check("t5_laser_rst", laser_rst, 1);
    check("t5_busy", busy, 0);
    check("t5_x", X, 0);
    check("t5_y", Y, 0);
    check("t5_res_valid", res_valid, 0);
    RST = 1'b0;
    step();
    start_run();
    steps(22);
    check("t5_cleared_x", X, 0);
    stream_steps(NPTS + 2 - 22, 1'b0);
    pulse_done(3, 2, 2, 2, 2);
    handshake(3);

    for (int r = 0; r < 4; r++) random_run();

`ifdef LASER_WDOG_EN
    start_run();
    steps(NPTS + 2);
    steps(WDOG - 1);
    check("t6_not_yet", res_valid, 0);
    step();
    check("t6_valid", res_valid, 1);
    check("t6_timeout", res_timeout, 1);
    check("t6_c1x", res_c1x, 0);
    check("t6_c2y", res_c2y, 0);
    handshake(2);
    random_run();
`else
    start_run();
    steps(NPTS + 2 + 150);
    check("t6_still_wait", res_valid, 0);
    check("t6_still_busy", busy, 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL global_timeout: got no finish, required finish before %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
